// File: rtl/inv_butterfly_row.sv
// Streaming inverse of the first 8-point DCT butterfly stage.
// Loads s0..s3,d0..d3 serially, then emits x0..x7 in natural order.
module inv_butterfly_row #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_err
);
  localparam logic LOAD = 1'b0;
  localparam logic EMIT = 1'b1;

  logic             state;
  logic [2:0]       cnt;
  logic [2:0]       nxt;
  logic [7:0][W:0]  buf_q;
  logic [7:0][W-1:0] samp;
  logic [7:0]       perr;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign nxt       = cnt + 3'd1;

  // One reconstruction lane per output index; x_k and x_(7-k) share a s/d pair.
  for (genvar k = 0; k < 8; k++) begin : g_x
    localparam int SI = (k < 4) ? k : 7 - k;
    logic signed [W+1:0] a, b, r;
    logic                unused_top;
    assign a = {buf_q[SI][W], buf_q[SI]};
    assign b = {buf_q[SI+4][W], buf_q[SI+4]};
    if (k < 4) begin : g_sum
      assign r = a + b;
    end else begin : g_dif
      assign r = a - b;
    end
    assign samp[k]    = r[W:1];
    // LSB of s+d equals LSB of s-d: odd means the pair was not a butterfly
    assign perr[k]    = r[0];
    assign unused_top = r[W+1];
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) buf_q[cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= 3'd0;
      out_data <= '0;
      out_last <= 1'b0;
      out_err  <= 1'b0;
    end else if (state == LOAD) begin
      if (in_valid) begin
        if (cnt == 3'd7) begin
          // x0 depends only on buf[0]/buf[4], already stored
          cnt      <= 3'd0;
          state    <= EMIT;
          out_data <= samp[0];
          out_err  <= perr[0];
          out_last <= 1'b0;
        end else begin
          cnt <= nxt;
        end
      end
    end else if (out_ready) begin
      if (cnt == 3'd7) begin
        cnt   <= 3'd0;
        state <= LOAD;
      end else begin
        cnt      <= nxt;
        out_data <= samp[nxt];
        out_err  <= perr[nxt];
        out_last <= (nxt == 3'd7);
      end
    end
  end
endmodule

// File: tb/tb_inv_butterfly_row.sv
// Directed bench for inv_butterfly_row: rows, extremes, odd pairs, stalls, resets.
module tb_inv_butterfly_row;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [8:0] in_data = '0;
  logic       in_ready, out_valid, out_last, out_err;
  logic [7:0] out_data;

  int checks = 0;
  int failures = 0;

  logic signed [8:0] row_in [8];
  logic signed [7:0] exp_x  [8];
  logic signed [7:0] got_d  [8];
  logic              got_l  [8];
  logic              got_e  [8];
  logic              got_to;
  logic              vld_in_load;

  inv_butterfly_row #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic load_row1();
    row_in = '{11, -10, 132, -128, 9, 4, 122, -128};
    exp_x  = '{10, -3, 127, -128, 0, 5, -7, 1};
  endtask

  // Drives row_in in LOAD; ends 1 time unit after the edge that accepts d3.
  task automatic send_row(input int max_gap);
    vld_in_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b0;
      if (max_gap > 0)
        repeat (int'($urandom_range(0, max_gap))) begin
          @(posedge clk); #1;
          if (out_valid) vld_in_load = 1'b1;
        end
      in_valid = 1'b1;
      in_data  = row_in[i];
      if (out_valid) vld_in_load = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Collects eight samples with out_ready high; flags a timeout instead of hanging.
  task automatic recv_row();
    got_to = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int w = 0;
      while (!out_valid && w < 50) begin
        @(posedge clk); #1; w++;
      end
      if (!out_valid) got_to = 1'b1;
      got_d[i] = out_data;
      got_l[i] = out_last;
      got_e[i] = out_err;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, out_err} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%0d last=%b err=%b, need 1 0 0 0 0",
               in_ready, out_valid, out_data, out_last, out_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    load_row1();
    out_ready = 1'b1;
    send_row(0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: got vld=%b rdy=%b after d3, need 1 0", out_valid, in_ready);
    end
    checks++;
    if (vld_in_load !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: out_valid seen during load, need 0");
    end
    recv_row();
    checks++;
    if (got_to !== 1'b0) begin
      failures++;
      $display("FAIL basic_timeout: got timeout, need none");
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== exp_x[i] || got_l[i] !== (i == 7) || got_e[i] !== 1'b0) begin
        failures++;
        $display("FAIL basic_x%0d: got data=%0d last=%b err=%b, need data=%0d last=%b err=0",
                 i, got_d[i], got_l[i], got_e[i], exp_x[i], (i == 7));
      end
    end
  endtask

  task automatic test_extremes();
    row_in = '{-1, 0, 0, 0, 255, 0, 0, 0};
    exp_x  = '{127, 0, 0, 0, 0, 0, 0, -128};
    send_row(0);
    recv_row();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== exp_x[i] || got_e[i] !== 1'b0 || got_to !== 1'b0) begin
        failures++;
        $display("FAIL extremes_x%0d: got data=%0d err=%b to=%b, need data=%0d err=0",
                 i, got_d[i], got_e[i], got_to, exp_x[i]);
      end
    end
  endtask

  task automatic test_odd_pair();
    row_in = '{1, 0, 0, 0, 0, 0, 0, 0};
    send_row(0);
    recv_row();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== 8'sd0 || got_e[i] !== (i == 0 || i == 7) || got_to !== 1'b0) begin
        failures++;
        $display("FAIL odd_x%0d: got data=%0d err=%b, need data=0 err=%b",
                 i, got_d[i], got_e[i], (i == 0 || i == 7));
      end
    end
  endtask

  task automatic test_backpressure();
    load_row1();
    send_row(2);
    got_to = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int w = 0;
      while (!out_valid && w < 50) begin
        @(posedge clk); #1; w++;
      end
      if (!out_valid) got_to = 1'b1;
      if (i == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          in_valid = 1'b1;
          in_data  = 9'h0AA;
          @(posedge clk); #1;
          checks++;
          if (out_valid !== 1'b1 || out_data !== exp_x[2] || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold_%0d: got vld=%b data=%0d rdy=%b, need 1 %0d 0",
                     s, out_valid, $signed(out_data), in_ready, exp_x[2]);
          end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      got_d[i] = out_data;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== exp_x[i] || got_to !== 1'b0) begin
        failures++;
        $display("FAIL stall_x%0d: got %0d to=%b, need %0d", i, got_d[i], got_to, exp_x[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 9'sd77;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_load_state: got rdy=%b vld=%b, need 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_row1();
    send_row(0);
    recv_row();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== exp_x[i] || got_l[i] !== (i == 7) || got_to !== 1'b0) begin
        failures++;
        $display("FAIL rst_load_x%0d: got %0d last=%b, need %0d last=%b",
                 i, got_d[i], got_l[i], exp_x[i], (i == 7));
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    load_row1();
    send_row(0);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_x[3]) begin
      failures++;
      $display("FAIL rst_emit_x3: got vld=%b data=%0d, need 1 %0d", out_valid, $signed(out_data), exp_x[3]);
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_emit_drop: got vld=%b data=%0d rdy=%b, need 0 0 1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_emit_release: got rdy=%b vld=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [8:0] words [16];
    logic signed [7:0] exp2  [16];
    logic signed [7:0] got2  [16];
    int ocyc [16];
    int idx = 0;
    int oidx = 0;
    words = '{11, -10, 132, -128, 9, 4, 122, -128, -1, 0, 0, 0, 255, 0, 0, 0};
    exp2  = '{10, -3, 127, -128, 0, 5, -7, 1, 127, 0, 0, 0, 0, 0, 0, -128};
    out_ready = 1'b1;
    for (int c = 0; c < 80 && oidx < 16; c++) begin
      if (in_ready && idx < 16) begin
        in_valid = 1'b1;
        in_data  = words[idx];
        idx++;
      end else begin
        in_valid = (idx < 16);
      end
      if (out_valid) begin
        got2[oidx] = out_data;
        ocyc[oidx] = c;
        oidx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (oidx !== 16) begin
      failures++;
      $display("FAIL b2b_count: got %0d samples, need 16", oidx);
    end else begin
      checks++;
      if (ocyc[8] - ocyc[0] !== 16 || ocyc[7] - ocyc[0] !== 7) begin
        failures++;
        $display("FAIL b2b_period: got period=%0d emit_span=%0d, need 16 7",
                 ocyc[8] - ocyc[0], ocyc[7] - ocyc[0]);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got2[i] !== exp2[i]) begin
          failures++;
          $display("FAIL b2b_s%0d: got %0d, need %0d", i, got2[i], exp2[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_odd_pair();
    test_backpressure();
    test_reset_mid_load();
    test_reset_mid_emit();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
